grant_decoder: RTL and testbench
================================

# grant_decoder

Inverse companion of the LSB priority encoder in the memory-controller arbitration path. Takes a winning requester index from an upstream selector over a valid/ready handshake. Drives a registered one-hot grant vector to the request queues and holds it until the granted queue acknowledges. It then enforces a programmable idle gap before accepting the next index.

## Interface

Parameters:
- vector_length, 8, number of requesters / grant lines
- index_length, $clog2(vector_length), index width
- gap_cycles, 2, idle cycles between grant release and next acceptance (0 allowed)
- gap_width, $clog2(gap_cycles+1), gap counter width

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream index valid
- in_index  input  index_length  requester index to grant
- in_ready  output  1  block can accept an index (high only in GD_IDLE)
- grant  output  vector_length  registered one-hot grant, at most one bit set
- grant_valid  output  1  registered, high while grant is non-zero
- grant_index  output  index_length  registered copy of the granted index
- ack  input  vector_length  per-requester completion, sampled only in GD_GRANT
- err_index  output  1  one-cycle registered pulse: index ≥ vector_length was offered and dropped
- spurious_ack  output  1  one-cycle registered pulse: ack bit other than grant_index seen in GD_GRANT

## Operation

- Reset (rst_n low, asynchronous) drives these values:
  - state = GD_IDLE
  - grant = 0, grant_valid = 0, grant_index = 0
  - gap counter = 0
  - err_index = 0, spurious_ack = 0
- in_ready is decoded from the state register (state == GD_IDLE), so it is 1 during and immediately after reset.
- GD_IDLE, on in_valid:
  - If in_index < vector_length: register grant = 1 << in_index, grant_index = in_index, grant_valid = 1, go to GD_GRANT.
  - Otherwise: pulse err_index, no grant, stay in GD_IDLE. The handshake still completes (in_ready was high), so the index is consumed.
- GD_GRANT:
  - in_ready = 0.
  - If ack[grant_index] = 1: clear grant, grant_valid and the index-consumption state.
    - gap_cycles > 0: load the gap counter with gap_cycles, go to GD_GAP.
    - gap_cycles = 0: go to GD_IDLE.
  - Any other ack bit set in the same cycle pulses spurious_ack. This happens whether or not the true ack is present, and has no other effect.
- GD_GAP:
  - in_ready = 0, grant = 0.
  - The counter decrements each cycle; go to GD_IDLE when it reaches 1 → 0.
  - ack is ignored.
- grant_index holds its last value after release. Only grant/grant_valid are cleared.
- in_index is never sampled outside GD_IDLE. in_valid held high across GD_GRANT/GD_GAP is not lost: it is accepted on the first GD_IDLE cycle.

## Timing

- Accept at edge N (in_valid & in_ready): grant/grant_valid/grant_index are visible in cycle N+1. Latency is 1 cycle.
- ack[grant_index] sampled high at edge M:
  - grant is low from cycle M+1.
  - in_ready is high in cycle M+1+gap_cycles.
  - The earliest next accept edge is M+1+gap_cycles.
- Minimum grant width is 1 cycle: an ack present in the first GRANT cycle releases on that edge.
- Minimum accept-to-accept period is 2+gap_cycles cycles.
- err_index and spurious_ack are high exactly one cycle, in the cycle after the offending edge.
- Reset asserted mid-grant or mid-gap clears grant combinationally with rst_n. There is no completion pulse, and the pending ack is discarded.

## Structure

- MemoryController_Definitions gains:
  - typedef enum logic [1:0] {GD_IDLE, GD_GRANT, GD_GAP} grant_state_t
  - default constant GRANT_GAP_CYCLES = 2
- One sub-module, onehot_decoder, handles the combinational index→one-hot decode.
  - Parameters: vector_length, index_length.
  - Outputs 0 for out-of-range input and flags the out-of-range condition. The range flag feeds err_index.
- Registers: state, grant, grant_index, gap counter, two pulse flops.

## Test plan

- Reset release, vector_length=8, gap_cycles=2:
  - All outputs 0 except in_ready=1.
  - Offer index 5 at edge 0 → grant=8'b0010_0000, grant_index=5 in cycle 1.
  - ack=8'b0010_0000 at edge 4 → grant=0 from cycle 5, in_ready=0 in cycles 5-6, in_ready=1 in cycle 7.
- Back-to-back: in_valid held high with index 0 then 7.
  - Second grant (8'b1000_0000) appears exactly 2+gap_cycles cycles after the first ack edge.
  - Index 7 is not sampled early.
- vector_length=6: offer index 6 → err_index pulses 1 cycle, no grant, in_ready stays 1. Then index 1 → grant=6'b000010.
- During grant of index 3, ack=8'b0000_0101 → spurious_ack pulses, grant held. Then ack=8'b0000_1001 → spurious_ack pulses and grant releases on the same edge.
- gap_cycles=0: ack in the first grant cycle → grant low next cycle, in_ready high the same cycle, new index accepted that edge.
- rst_n asserted asynchronously mid-GD_GRANT and mid-GD_GAP:
  - grant=0 immediately, state GD_IDLE.
  - After release, the next accept behaves as the first scenario.

Source files
------------

// File: rtl/grant_decoder_pkg.sv
// grant_decoder_pkg: shared types and defaults for the grant decoder.
//   grant_state_t    - controller states (idle, grant held, idle gap)
//   GRANT_GAP_CYCLES - default idle gap between grant release and next accept
package grant_decoder_pkg;

    typedef enum logic [1:0] {
        GD_IDLE  = 2'd0,
        GD_GRANT = 2'd1,
        GD_GAP   = 2'd2
    } grant_state_t;

    localparam int GRANT_GAP_CYCLES = 32'd2;

endpackage : grant_decoder_pkg

// File: rtl/grant_decoder_if.sv
// grant_decoder_if: index handshake, grant outputs and ack/status lines of
// the grant decoder.
//   master - upstream selector / request queues side (drives index and ack)
//   slave  - grant decoder side (drives ready, grant and status pulses)
interface grant_decoder_if #(
    parameter int vector_length = 32'd8,
    parameter int index_length  = $clog2(vector_length)
) ();

    logic                     in_valid;
    logic [index_length-1:0]  in_index;
    logic                     in_ready;
    logic [vector_length-1:0] grant;
    logic                     grant_valid;
    logic [index_length-1:0]  grant_index;
    logic [vector_length-1:0] ack;
    logic                     err_index;
    logic                     spurious_ack;

    modport master (
        output in_valid, in_index, ack,
        input  in_ready, grant, grant_valid, grant_index, err_index, spurious_ack
    );

    modport slave (
        input  in_valid, in_index, ack,
        output in_ready, grant, grant_valid, grant_index, err_index, spurious_ack
    );

endinterface : grant_decoder_if

// File: rtl/grant_decoder_onehot_decoder.sv
// onehot_decoder: combinational index -> one-hot decode.
//   index        - binary requester index
//   onehot       - one-hot vector, all zero when index is out of range
//   out_of_range - high when index >= vector_length
module onehot_decoder #(
    parameter int vector_length = 32'd8,
    parameter int index_length  = $clog2(vector_length)
) (
    input  logic [index_length-1:0]  index,
    output logic [vector_length-1:0] onehot,
    output logic                     out_of_range
);

    // One bit wider than the index so vector_length itself is representable.
    localparam logic [index_length:0]    limit_c = (index_length + 1)'(vector_length);
    localparam logic [vector_length-1:0] base_c  = vector_length'(32'd1);

    // Range-qualified decode; out-of-range indices produce an all-zero vector.
    always_comb begin
        onehot       = '0;
        out_of_range = 1'b1;
        if ({1'b0, index} < limit_c) begin
            onehot       = base_c << index;
            out_of_range = 1'b0;
        end else begin
            onehot       = '0;
            out_of_range = 1'b1;
        end
    end

endmodule : onehot_decoder

// File: rtl/grant_decoder.sv
// grant_decoder: accepts a winning requester index over valid/ready, drives a
// registered one-hot grant until the granted queue acks, then waits a
// programmable idle gap before accepting the next index.
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - slave side of grant_decoder_if (index handshake, grant,
//                grant_valid, grant_index, ack, err_index, spurious_ack)
module grant_decoder
    import grant_decoder_pkg::*;
#(
    parameter int vector_length = 32'd8,
    parameter int index_length  = $clog2(vector_length),
    parameter int gap_cycles    = GRANT_GAP_CYCLES,
    parameter int gap_width     = $clog2(gap_cycles + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    grant_decoder_if.slave bus
);

    // With gap_cycles = 0 the counter is never used but still needs one bit.
    localparam int               gap_w      = (gap_width < 32'd1) ? 32'd1 : gap_width;
    localparam logic [gap_w-1:0] gap_load_c = gap_w'(gap_cycles);
    localparam logic [gap_w-1:0] gap_one_c  = gap_w'(32'd1);

    grant_state_t             state_r, state_s;
    logic [vector_length-1:0] grant_r, grant_s;
    logic                     grant_valid_r, grant_valid_s;
    logic [index_length-1:0]  grant_index_r, grant_index_s;
    logic [gap_w-1:0]         gap_cnt_r, gap_cnt_s;
    logic                     err_index_r, err_index_s;
    logic                     spurious_ack_r, spurious_ack_s;

    logic [vector_length-1:0] decoded_s;
    logic                     out_of_range_s;
    logic                     ack_hit_s;
    logic                     ack_other_s;

    onehot_decoder #(
        .vector_length (vector_length),
        .index_length  (index_length)
    ) u_onehot_decoder (
        .index        (bus.in_index),
        .onehot       (decoded_s),
        .out_of_range (out_of_range_s)
    );

    // While granting, grant_r is exactly 1 << grant_index_r, so masking with
    // it separates the true ack from every other ack bit.
    assign ack_hit_s   = |(bus.ack & grant_r);
    assign ack_other_s = |(bus.ack & ~grant_r);

    // Next-state and next-output logic for the grant controller.
    always_comb begin
        state_s        = state_r;
        grant_s        = grant_r;
        grant_valid_s  = grant_valid_r;
        grant_index_s  = grant_index_r;
        gap_cnt_s      = gap_cnt_r;
        err_index_s    = 1'b0;
        spurious_ack_s = 1'b0;
        case (state_r)
            GD_IDLE: begin
                if (bus.in_valid) begin
                    if (out_of_range_s) begin
                        // Index is consumed by the handshake but dropped.
                        err_index_s = 1'b1;
                    end else begin
                        grant_s       = decoded_s;
                        grant_index_s = bus.in_index;
                        grant_valid_s = 1'b1;
                        state_s       = GD_GRANT;
                    end
                end else begin
                    state_s = GD_IDLE;
                end
            end
            GD_GRANT: begin
                spurious_ack_s = ack_other_s;
                if (ack_hit_s) begin
                    grant_s       = '0;
                    grant_valid_s = 1'b0;
                    if (gap_cycles > 32'd0) begin
                        gap_cnt_s = gap_load_c;
                        state_s   = GD_GAP;
                    end else begin
                        state_s = GD_IDLE;
                    end
                end else begin
                    state_s = GD_GRANT;
                end
            end
            GD_GAP: begin
                if (gap_cnt_r <= gap_one_c) begin
                    gap_cnt_s = '0;
                    state_s   = GD_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r - gap_one_c;
                end
            end
            default: begin
                state_s       = GD_IDLE;
                grant_s       = '0;
                grant_valid_s = 1'b0;
                gap_cnt_s     = '0;
            end
        endcase
    end

    // State and output registers; reset clears the grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= GD_IDLE;
            grant_r        <= '0;
            grant_valid_r  <= 1'b0;
            grant_index_r  <= '0;
            gap_cnt_r      <= '0;
            err_index_r    <= 1'b0;
            spurious_ack_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            grant_r        <= grant_s;
            grant_valid_r  <= grant_valid_s;
            grant_index_r  <= grant_index_s;
            gap_cnt_r      <= gap_cnt_s;
            err_index_r    <= err_index_s;
            spurious_ack_r <= spurious_ack_s;
        end
    end

    assign bus.in_ready     = (state_r == GD_IDLE);
    assign bus.grant        = grant_r;
    assign bus.grant_valid  = grant_valid_r;
    assign bus.grant_index  = grant_index_r;
    assign bus.err_index    = err_index_r;
    assign bus.spurious_ack = spurious_ack_r;

endmodule : grant_decoder

// File: tb/tb_grant_decoder.sv
// tb_grant_decoder: directed self-checking bench for grant_decoder.
// Three instances: 8 lines / gap 2, 6 lines / gap 2, 8 lines / gap 0.
module tb_grant_decoder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    grant_decoder_if #(.vector_length(8), .index_length(3)) if8 ();
    grant_decoder_if #(.vector_length(6), .index_length(3)) if6 ();
    grant_decoder_if #(.vector_length(8), .index_length(3)) if0 ();

    grant_decoder #(.vector_length(8), .index_length(3), .gap_cycles(2)) u_dut8 (
        .clk (clk), .rst_n (rst_n), .bus (if8)
    );
    grant_decoder #(.vector_length(6), .index_length(3), .gap_cycles(2)) u_dut6 (
        .clk (clk), .rst_n (rst_n), .bus (if6)
    );
    grant_decoder #(.vector_length(8), .index_length(3), .gap_cycles(0)) u_dut0 (
        .clk (clk), .rst_n (rst_n), .bus (if0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; outputs then show the following cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        if8.in_valid = 1'b0; if8.in_index = 3'd0; if8.ack = 8'h00;
        if6.in_valid = 1'b0; if6.in_index = 3'd0; if6.ack = 6'h00;
        if0.in_valid = 1'b0; if0.in_index = 3'd0; if0.ack = 8'h00;
        #2 rst_n = 1'b0;
        tick();
        tick();
        checks++; if (if8.grant !== 8'h00) begin errors++; $display("FAIL reset_grant: got %h expected %h", if8.grant, 8'h00); end
        checks++; if (if8.grant_valid !== 1'b0) begin errors++; $display("FAIL reset_grant_valid: got %b expected 0", if8.grant_valid); end
        checks++; if (if8.grant_index !== 3'd0) begin errors++; $display("FAIL reset_grant_index: got %0d expected 0", if8.grant_index); end
        checks++; if (if8.err_index !== 1'b0 || if8.spurious_ack !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b expected 00", if8.err_index, if8.spurious_ack); end
        checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", if8.in_ready); end
        #3 rst_n = 1'b1;
        tick();
        checks++; if (if8.in_ready !== 1'b1 || if8.grant !== 8'h00) begin errors++; $display("FAIL post_reset: ready %b grant %h expected 1 00", if8.in_ready, if8.grant); end
    endtask

    task automatic test_first_grant();
        if8.in_valid = 1'b1; if8.in_index = 3'd5;
        tick();                                   // edge 0
        if8.in_valid = 1'b0;
        checks++; if (if8.grant !== 8'h20) begin errors++; $display("FAIL first_grant: got %h expected %h", if8.grant, 8'h20); end
        checks++; if (if8.grant_index !== 3'd5 || if8.grant_valid !== 1'b1) begin errors++; $display("FAIL first_index: got %0d/%b expected 5/1", if8.grant_index, if8.grant_valid); end
        checks++; if (if8.in_ready !== 1'b0) begin errors++; $display("FAIL first_ready_low: got %b expected 0", if8.in_ready); end
        tick(); tick(); tick();                   // edges 1..3
        checks++; if (if8.grant !== 8'h20) begin errors++; $display("FAIL first_hold: got %h expected %h", if8.grant, 8'h20); end
        if8.ack = 8'h20;
        tick();                                   // edge 4
        if8.ack = 8'h00;
        checks++; if (if8.grant !== 8'h00 || if8.grant_valid !== 1'b0) begin errors++; $display("FAIL first_release: got %h/%b expected 00/0", if8.grant, if8.grant_valid); end
        checks++; if (if8.grant_index !== 3'd5) begin errors++; $display("FAIL first_index_held: got %0d expected 5", if8.grant_index); end
        checks++; if (if8.in_ready !== 1'b0) begin errors++; $display("FAIL gap_cycle5: got %b expected 0", if8.in_ready); end
        tick();
        checks++; if (if8.in_ready !== 1'b0) begin errors++; $display("FAIL gap_cycle6: got %b expected 0", if8.in_ready); end
        tick();
        checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL gap_cycle7: got %b expected 1", if8.in_ready); end
    endtask

    task automatic test_back_to_back();
        if8.in_valid = 1'b1; if8.in_index = 3'd0;
        tick();
        if8.in_index = 3'd7;                      // in_valid stays high
        checks++; if (if8.grant !== 8'h01) begin errors++; $display("FAIL b2b_first: got %h expected %h", if8.grant, 8'h01); end
        tick();
        checks++; if (if8.grant !== 8'h01 || if8.grant_index !== 3'd0) begin errors++; $display("FAIL b2b_no_early: got %h/%0d expected 01/0", if8.grant, if8.grant_index); end
        if8.ack = 8'h01;
        tick();                                   // ack edge M
        if8.ack = 8'h00;
        checks++; if (if8.grant !== 8'h00) begin errors++; $display("FAIL b2b_m1: got %h expected 00", if8.grant); end
        tick();
        checks++; if (if8.grant !== 8'h00 || if8.grant_index !== 3'd0) begin errors++; $display("FAIL b2b_m2: got %h/%0d expected 00/0", if8.grant, if8.grant_index); end
        tick();
        checks++; if (if8.grant !== 8'h00 || if8.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_m3: got %h/%b expected 00/1", if8.grant, if8.in_ready); end
        tick();                                   // accept at M+3
        if8.in_valid = 1'b0;
        checks++; if (if8.grant !== 8'h80 || if8.grant_index !== 3'd7) begin errors++; $display("FAIL b2b_second: got %h/%0d expected 80/7", if8.grant, if8.grant_index); end
        if8.ack = 8'h80;
        tick();
        if8.ack = 8'h00;
        tick(); tick();
    endtask

    task automatic test_err_index();
        if6.in_valid = 1'b1; if6.in_index = 3'd6;
        tick();
        if6.in_valid = 1'b0;
        checks++; if (if6.err_index !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b expected 1", if6.err_index); end
        checks++; if (if6.grant !== 6'h00 || if6.grant_valid !== 1'b0 || if6.in_ready !== 1'b1) begin errors++; $display("FAIL err_no_grant: got %h/%b/%b expected 00/0/1", if6.grant, if6.grant_valid, if6.in_ready); end
        tick();
        checks++; if (if6.err_index !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b expected 0", if6.err_index); end
        if6.in_valid = 1'b1; if6.in_index = 3'd1;
        tick();
        if6.in_valid = 1'b0;
        checks++; if (if6.grant !== 6'b000010 || if6.grant_index !== 3'd1) begin errors++; $display("FAIL err_then_grant: got %b/%0d expected 000010/1", if6.grant, if6.grant_index); end
        if6.ack = 6'b000010;
        tick();
        if6.ack = 6'h00;
        tick(); tick();
    endtask

    task automatic test_spurious_ack();
        if8.in_valid = 1'b1; if8.in_index = 3'd3;
        tick();
        if8.in_valid = 1'b0;
        if8.ack = 8'h05;
        tick();
        if8.ack = 8'h00;
        checks++; if (if8.spurious_ack !== 1'b1 || if8.grant !== 8'h08) begin errors++; $display("FAIL spur_hold: got %b/%h expected 1/08", if8.spurious_ack, if8.grant); end
        tick();
        checks++; if (if8.spurious_ack !== 1'b0 || if8.grant !== 8'h08) begin errors++; $display("FAIL spur_clear: got %b/%h expected 0/08", if8.spurious_ack, if8.grant); end
        if8.ack = 8'h09;
        tick();
        if8.ack = 8'h00;
        checks++; if (if8.spurious_ack !== 1'b1 || if8.grant !== 8'h00) begin errors++; $display("FAIL spur_release: got %b/%h expected 1/00", if8.spurious_ack, if8.grant); end
        tick();
        checks++; if (if8.spurious_ack !== 1'b0) begin errors++; $display("FAIL spur_one_cycle: got %b expected 0", if8.spurious_ack); end
        tick();
    endtask

    task automatic test_gap_zero();
        if0.in_valid = 1'b1; if0.in_index = 3'd2;
        tick();
        checks++; if (if0.grant !== 8'h04) begin errors++; $display("FAIL gap0_grant: got %h expected 04", if0.grant); end
        if0.ack = 8'h04; if0.in_index = 3'd6;     // in_valid still high
        tick();                                   // release in first grant cycle
        if0.ack = 8'h00;
        checks++; if (if0.grant !== 8'h00 || if0.in_ready !== 1'b1 || if0.grant_index !== 3'd2) begin errors++; $display("FAIL gap0_release: got %h/%b/%0d expected 00/1/2", if0.grant, if0.in_ready, if0.grant_index); end
        tick();
        if0.in_valid = 1'b0;
        checks++; if (if0.grant !== 8'h40 || if0.grant_index !== 3'd6) begin errors++; $display("FAIL gap0_next: got %h/%0d expected 40/6", if0.grant, if0.grant_index); end
        if0.ack = 8'h40;
        tick();
        if0.ack = 8'h00;
        checks++; if (if0.in_ready !== 1'b1 || if0.grant !== 8'h00) begin errors++; $display("FAIL gap0_idle: got %b/%h expected 1/00", if0.in_ready, if0.grant); end
    endtask

    task automatic test_reset_mid();
        if8.in_valid = 1'b1; if8.in_index = 3'd4;
        tick();
        if8.in_valid = 1'b0;
        checks++; if (if8.grant !== 8'h10) begin errors++; $display("FAIL mid_grant_setup: got %h expected 10", if8.grant); end
        if8.ack = 8'h10;                          // pending ack discarded by reset
        #2 rst_n = 1'b0;
        #1;
        checks++; if (if8.grant !== 8'h00 || if8.grant_valid !== 1'b0 || if8.in_ready !== 1'b1) begin errors++; $display("FAIL mid_grant_reset: got %h/%b/%b expected 00/0/1", if8.grant, if8.grant_valid, if8.in_ready); end
        checks++; if (if8.grant_index !== 3'd0 || if8.spurious_ack !== 1'b0) begin errors++; $display("FAIL mid_grant_index: got %0d/%b expected 0/0", if8.grant_index, if8.spurious_ack); end
        #1 rst_n = 1'b1;
        if8.ack = 8'h00;
        tick();
        if8.in_valid = 1'b1; if8.in_index = 3'd1;
        tick();
        if8.in_valid = 1'b0;
        if8.ack = 8'h02;
        tick();
        if8.ack = 8'h00;
        checks++; if (if8.in_ready !== 1'b0 || if8.grant !== 8'h00) begin errors++; $display("FAIL mid_gap_setup: got %b/%h expected 0/00", if8.in_ready, if8.grant); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (if8.in_ready !== 1'b1 || if8.grant !== 8'h00) begin errors++; $display("FAIL mid_gap_reset: got %b/%h expected 1/00", if8.in_ready, if8.grant); end
        #1 rst_n = 1'b1;
        tick();
        if8.in_valid = 1'b1; if8.in_index = 3'd5;
        tick();
        if8.in_valid = 1'b0;
        checks++; if (if8.grant !== 8'h20 || if8.grant_index !== 3'd5 || if8.in_ready !== 1'b0) begin errors++; $display("FAIL after_reset_grant: got %h/%0d/%b expected 20/5/0", if8.grant, if8.grant_index, if8.in_ready); end
        if8.ack = 8'h20;
        tick();
        if8.ack = 8'h00;
        tick(); tick();
        checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL after_reset_idle: got %b expected 1", if8.in_ready); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_first_grant();
        test_back_to_back();
        test_err_index();
        test_spurious_ack();
        test_gap_zero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_grant_decoder
